// File: rtl/fft_job_sequencer.sv
// fft_job_sequencer: frame-level sequencer around the in-place radix-2 FFT core.
// Loads N samples into bank 0, kicks the core, waits for finish (with timeout),
// then streams the final-stage bank out through a 2-deep skid buffer.
// Build option: define FFT_BITREV_LOAD_EN to store loaded samples at the
// bit-reversed address (natural input order -> bit-reversed storage).
module fft_job_sequencer #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*DATA_WIDTH-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic                      out_last,
  output logic                      fft_start,
  input  logic                      fft_finish,
  output logic                      mem_bank,
  output logic [$clog2(N)-1:0]      mem_addr,
  output logic                      mem_we,
  output logic [2*DATA_WIDTH-1:0]   mem_wdata,
  input  logic [2*DATA_WIDTH-1:0]   mem_rdata,
  output logic                      busy,
  output logic                      error
);

  localparam int AW = $clog2(N);
  localparam int RW = $clog2(TIMEOUT + 1);
  localparam int SW = 2 * DATA_WIDTH;
  // Stage s writes bank ~(s & 1); the last stage is log2(N)-1.
  localparam logic FINAL_BANK = (((AW - 1) % 2) == 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {S_LOAD, S_START, S_RUN, S_UNLOAD, S_ERR} state_t;

  state_t             state, state_nxt;
  logic [AW-1:0]      load_cnt, load_addr;
  logic [RW-1:0]      run_cnt;
  logic [AW:0]        rd_addr;     // extra bit marks "all N reads issued"
  logic               rd_pend;     // mem_rdata carries a requested word this cycle
  logic [1:0][SW-1:0] buf_q;
  logic               buf_head;
  logic [1:0]         buf_cnt;
  logic [AW-1:0]      out_cnt;
  logic               err_q;
  logic               pop, rd_issue, tail;
  logic [2:0]         occ_after;

`ifdef FFT_BITREV_LOAD_EN
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction
  assign load_addr = bitrev(load_cnt);
`else
  assign load_addr = load_cnt;
`endif

  assign out_valid = (state == S_UNLOAD) && (buf_cnt != 2'd0);
  assign out_data  = buf_q[buf_head];
  assign out_last  = out_valid && (out_cnt == AW'(N - 1));
  assign pop       = out_valid && out_ready;
  // Occupancy once this cycle's landing word and pop are applied; a read issued
  // now lands next cycle, so it must fit even if nothing is popped then.
  assign occ_after = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign rd_issue  = (state == S_UNLOAD) && !rd_addr[AW] && (occ_after <= 3'd1);
  assign tail      = buf_head ^ buf_cnt[0];
  assign mem_wdata = in_data;
  assign error     = err_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_LOAD;
    else        state <= state_nxt;
  end

  // Next-state and per-state control outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    fft_start = 1'b0;
    busy      = 1'b0;
    mem_bank  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    case (state)
      S_LOAD: begin
        in_ready = 1'b1;
        mem_addr = load_addr;
        mem_we   = in_valid;
        if (in_valid && load_cnt == AW'(N - 1)) state_nxt = S_START;
      end
      S_START: begin
        fft_start = 1'b1;
        busy      = 1'b1;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // finish takes priority over a coincident timeout
        if (fft_finish)                          state_nxt = S_UNLOAD;
        else if (run_cnt == RW'(TIMEOUT - 1))    state_nxt = S_ERR;
      end
      S_UNLOAD: begin
        mem_bank = FINAL_BANK;
        mem_addr = rd_addr[AW-1:0];
        if (pop && out_last) state_nxt = S_LOAD;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_LOAD;
    endcase
  end

  // Load/run counters and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_cnt <= '0;
      run_cnt  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != S_LOAD)  load_cnt <= '0;
      else if (in_valid)    load_cnt <= load_cnt + AW'(1);
      if (state == S_START) run_cnt <= '0;
      else if (state == S_RUN && run_cnt != RW'(TIMEOUT)) run_cnt <= run_cnt + RW'(1);
      if (state == S_RUN && state_nxt == S_ERR) err_q <= 1'b1;
    end
  end

  // Unload read issue and 2-entry output buffer
  always_ff @(posedge clk) begin
    if (!rst_n || state != S_UNLOAD) begin
      rd_addr  <= '0;
      rd_pend  <= 1'b0;
      buf_q    <= '0;
      buf_head <= 1'b0;
      buf_cnt  <= 2'd0;
      out_cnt  <= '0;
    end else begin
      rd_pend <= rd_issue;
      if (rd_issue) rd_addr <= rd_addr + (AW+1)'(1);
      if (rd_pend)  buf_q[tail] <= mem_rdata;
      if (pop) begin
        buf_head <= ~buf_head;
        out_cnt  <= out_cnt + AW'(1);
      end
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_fft_job_sequencer.sv
// Self-checking bench for fft_job_sequencer (N=8, TIMEOUT=64). The FFT core is
// stood in for by a RAM model plus hand-driven fft_finish; bank 1 is preloaded
// with the "results" that unload must stream out in address order.
module tb_fft_job_sequencer;
  localparam int N  = 8;
  localparam int DW = 16;
  localparam int SW = 2 * DW;
  localparam int AW = 3;
  localparam int TO = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, fft_finish = 1'b0;
  logic [SW-1:0] in_data = '0;
  logic [SW-1:0] mem_rdata;
  logic          in_ready, out_valid, out_last, fft_start, mem_bank, mem_we, busy, error;
  logic [SW-1:0] out_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  fft_job_sequencer #(.N(N), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fft_start(fft_start), .fft_finish(fft_finish),
    .mem_bank(mem_bank), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Ping-pong RAM model: bank 0 written by the sequencer, bank 1 holds results.
  logic [SW-1:0] bank0 [N];
  logic [SW-1:0] bank1 [N];
  logic [SW-1:0] sent  [N];
  int            stray_wr = 0;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_bank == 1'b0) bank0[mem_addr] <= mem_wdata;
      else                  stray_wr <= stray_wr + 1;
    end
    mem_rdata <= mem_bank ? bank1[mem_addr] : bank0[mem_addr];
  end

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Storage slot of the k-th loaded sample.
  function automatic int load_slot(input int k);
    int r = 0;
`ifdef FFT_BITREV_LOAD_EN
    for (int i = 0; i < AW; i++) if ((k >> i) & 1) r += 1 << (AW - 1 - i);
`else
    r = k;
`endif
    return r;
  endfunction

  typedef struct {
    logic          iv;
    logic [SW-1:0] din;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic          e_rdy;
    logic          e_start;
    logic          e_busy;
  } vec_t;
  vec_t tbl [10];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check_bank0();
    for (int k = 0; k < N; k++) chk("bank0_contents", bank0[load_slot(k)], sent[k]);
  endtask

  // Load N beats with random gaps and ignored fft_finish noise; returns at the
  // start of the second RUN cycle (fft_start cycle + 2).
  task automatic load_frame(input int gap_pct);
    int k = 0, cyc = 0;
    while (k < N && cyc < 400) begin
      in_valid   = ($urandom_range(0, 99) >= gap_pct);
      in_data    = $urandom;
      fft_finish = $urandom_range(0, 1);
      @(negedge clk);
      chk("load_in_ready", in_ready, 1'b1);
      chk("load_we", mem_we, in_valid);
      if (in_valid) begin
        chk("load_addr", mem_addr, load_slot(k));
        chk("load_bank", mem_bank, 1'b0);
        sent[k] = in_data;
        k++;
      end
      tick(); cyc++;
    end
    chk("load_beats", k, N);
    in_valid = 1'b1; in_data = $urandom; fft_finish = 1'b1;
    @(negedge clk);
    chk("start_pulse", fft_start, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_in_ready", in_ready, 1'b0);
    chk("start_no_we", mem_we, 1'b0);
    tick();
    in_valid = 1'b0; fft_finish = 1'b0;
    @(negedge clk);
    chk("start_one_cycle", fft_start, 1'b0);
    chk("run_busy", busy, 1'b1);
    check_bank0();
    tick();
  endtask

  // Called at fft_start cycle + 2; pulses fft_finish in cycle fft_start + d.
  task automatic run_wait(input int d);
    for (int c = 2; c < d; c++) begin
      in_valid = $urandom_range(0, 1);
      @(negedge clk);
      chk("run_busy", busy, 1'b1);
      chk("run_no_we", mem_we, 1'b0);
      chk("run_no_error", error, 1'b0);
      tick();
    end
    in_valid = 1'b0; fft_finish = 1'b1;
    @(negedge clk);
    chk("finish_busy", busy, 1'b1);
    tick();
    fft_finish = 1'b0;
  endtask

  // Drain the frame. mode 0: ready high, 1: fixed toggle pattern, 2: random.
  // abort_at >= 0 applies reset while that beat is presented.
  task automatic unload_frame(input int mode, input int abort_at);
    int beat = 0, cyc = 0, first = -1;
    logic held = 1'b0;
    logic [SW-1:0] held_d = '0;
    logic [5:0] pat = 6'b101001; // bit i = ready in cycle i mod 6: 1,0,0,1,0,1
    while (beat < N && cyc < 200) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[cyc % 6];
        default: out_ready = $urandom_range(0, 1);
      endcase
      in_valid = $urandom_range(0, 1);
      @(negedge clk);
      chk("unload_no_we", mem_we, 1'b0);
      chk("unload_busy", busy, 1'b0);
      if (held) chk("valid_held", out_valid, 1'b1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        if (held) chk("hold_stable", out_data, held_d);
        if (beat == abort_at) begin
          rst_n = 1'b0; out_ready = 1'b0;
          tick();
          rst_n = 1'b1; in_valid = 1'b0;
          @(negedge clk);
          chk("rst_out_valid", out_valid, 1'b0);
          chk("rst_in_ready", in_ready, 1'b1);
          chk("rst_busy", busy, 1'b0);
          tick();
          return;
        end
        chk("unload_bank", mem_bank, 1'b1);
        if (out_ready) begin
          chk("out_data", out_data, bank1[beat]);
          chk("out_last", out_last, beat == N - 1);
          beat++; held = 1'b0;
        end else begin
          held = 1'b1; held_d = out_data;
        end
      end
      tick(); cyc++;
    end
    chk("unload_beats", beat, N);
    if (mode == 0) begin
      chk("unload_first_latency", first, 2);
      chk("unload_cycles", cyc, N + 2);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rearm_in_ready", in_ready, 1'b1);
    chk("rearm_no_extra_beat", out_valid, 1'b0);
    chk("rearm_busy", busy, 1'b0);
    tick();
    out_ready = 1'b0;
  endtask

  task automatic rand_bank1();
    for (int k = 0; k < N; k++) bank1[k] = $urandom;
  endtask

  initial begin
    for (int r = 0; r < N; r++)
      tbl[r] = '{1'b1, SW'((r + 1) << 16), 1'b1, AW'(load_slot(r)), 1'b1, 1'b0, 1'b0};
    tbl[8] = '{1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 32'h0,        1'b0, '0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < N; k++) bank1[k] = 32'h00A00000 | k;

    // Reset state
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_fft_start", fft_start, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_bank", mem_bank, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    rst_n = 1'b1;

    // Back-to-back load, start pulse, first RUN cycle
    for (int r = 0; r < 10; r++) begin
      in_valid = tbl[r].iv; in_data = tbl[r].din;
      if (r < N) sent[r] = tbl[r].din;
      @(negedge clk);
      chk("tbl_we", mem_we, tbl[r].e_we);
      if (tbl[r].e_we) begin
        chk("tbl_addr", mem_addr, tbl[r].e_addr);
        chk("tbl_bank", mem_bank, 1'b0);
      end
      chk("tbl_in_ready", in_ready, tbl[r].e_rdy);
      chk("tbl_fft_start", fft_start, tbl[r].e_start);
      chk("tbl_busy", busy, tbl[r].e_busy);
      tick();
    end
    check_bank0();
    run_wait(20);
    unload_frame(0, -1);

    // Toggled backpressure
    rand_bank1();
    load_frame(0);
    run_wait(5);
    unload_frame(1, -1);

    // Random frames
    for (int i = 0; i < 4; i++) begin
      rand_bank1();
      load_frame(30);
      run_wait($urandom_range(2, 40));
      unload_frame(2, -1);
    end

    // Finish coinciding with the last RUN cycle before timeout
    rand_bank1();
    load_frame(0);
    run_wait(TO);
    unload_frame(0, -1);

    // Reset during unload beat 3, then a complete frame
    rand_bank1();
    load_frame(0);
    run_wait(3);
    unload_frame(0, 3);
    rand_bank1();
    load_frame(20);
    run_wait(10);
    unload_frame(2, -1);

    // Timeout: RUN lasts TIMEOUT cycles, ERR from the next one
    load_frame(0);
    for (int c = 2; c <= TO; c++) begin
      @(negedge clk);
      chk("to_no_error_yet", error, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; fft_finish = $urandom_range(0, 1); out_ready = 1'b1;
      @(negedge clk);
      chk("to_error", error, 1'b1);
      chk("to_in_ready", in_ready, 1'b0);
      chk("to_out_valid", out_valid, 1'b0);
      chk("to_no_we", mem_we, 1'b0);
      tick();
    end
    in_valid = 1'b0; fft_finish = 1'b0; out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("to_rst_error", error, 1'b0);
    chk("to_rst_in_ready", in_ready, 1'b1);
    tick();

    chk("stray_bank1_writes", stray_wr, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
